elbeth_mem_arbiter: RTL and testbench

Two-requester arbiter sharing one single-ported memory bus between the instruction fetch port (IF stage) and the data port (EX/MEM stage) of the ELBETH core. It latches the winning request, drives the shared bus until the memory answers, and returns per-requester `ready`, read data and error. Its `imem_ready`/`dmem_ready` outputs drive the `if_imem_ready`/`exs_dmem_ready` inputs of the control unit, which generates the pipeline stalls.

---
 rtl/elbeth_mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_elbeth_mem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elbeth_mem_arbiter.sv
// elbeth_mem_arbiter: shares one single-ported memory bus between the
// instruction fetch port and the data port. Data has fixed priority.
// The winning request is latched into registered bus outputs and held
// until the memory answers. An IDLE cycle always separates two accesses.
//
// Optional feature: define ELBETH_ARB_TIMEOUT_EN to build a busy-cycle
// counter. It forces an error completion after TIMEOUT busy cycles
// without mem_ready. When the macro is undefined, BUSY waits indefinitely.
//
// state  | meaning
// IDLE   | no access on the bus; sample requests (data first)
// BUSY_I | fetch access on the bus, waiting for mem_ready
// BUSY_D | data access on the bus, waiting for mem_ready
module elbeth_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_en,
  output logic [DATA_WIDTH-1:0] imem_data,
  output logic                  imem_ready,
  output logic                  imem_error,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic                  dmem_en,
  input  logic [3:0]            dmem_rw,
  input  logic [DATA_WIDTH-1:0] dmem_data_w,
  output logic [DATA_WIDTH-1:0] dmem_data_r,
  output logic                  dmem_ready,
  output logic                  dmem_error,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_en,
  output logic [3:0]            mem_rw,
  output logic [DATA_WIDTH-1:0] mem_data_w,
  input  logic [DATA_WIDTH-1:0] mem_data_r,
  input  logic                  mem_ready,
  input  logic                  mem_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_en;
  logic [3:0]            r_mem_rw;
  logic [DATA_WIDTH-1:0] r_mem_data_w;

  logic w_busy;
  logic w_timeout;
  logic w_done;
  logic w_err;

  assign w_busy = (r_state != S_IDLE);

`ifdef ELBETH_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] r_cnt;

  // Busy-cycle counter: zero in IDLE so it starts cleared on BUSY entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (!w_busy) begin
      r_cnt <= '0;
    end else if (!mem_ready) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // A real mem_ready in the last allowed cycle wins over the timeout.
  assign w_timeout = w_busy & ~mem_ready & (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_timeout = 1'b0;
`endif

  assign w_done = w_busy & (mem_ready | w_timeout);
  assign w_err  = (mem_ready & mem_error) | w_timeout;

  // Arbitration and bus registers; a completion always returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_mem_addr   <= '0;
      r_mem_en     <= 1'b0;
      r_mem_rw     <= 4'b0000;
      r_mem_data_w <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (dmem_en) begin
            r_state      <= S_BUSY_D;
            r_mem_en     <= 1'b1;
            r_mem_addr   <= dmem_addr;
            r_mem_rw     <= dmem_rw;
            r_mem_data_w <= dmem_data_w;
          end else if (imem_en) begin
            r_state      <= S_BUSY_I;
            r_mem_en     <= 1'b1;
            r_mem_addr   <= imem_addr;
            r_mem_rw     <= 4'b0000;
            r_mem_data_w <= '0;
          end else begin
            r_mem_en <= 1'b0;
          end
        end
        S_BUSY_I, S_BUSY_D: begin
          if (w_done) begin
            r_state  <= S_IDLE;
            r_mem_en <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  // Responses are gated by the requester's own en so a flushed access
  // completes on the bus without producing a ready pulse.
  always_comb begin
    imem_ready = (r_state == S_BUSY_I) & w_done & imem_en;
    dmem_ready = (r_state == S_BUSY_D) & w_done & dmem_en;
    imem_error = imem_ready & w_err;
    dmem_error = dmem_ready & w_err;
  end

  assign imem_data   = mem_data_r;
  assign dmem_data_r = mem_data_r;

  assign mem_addr   = r_mem_addr;
  assign mem_en     = r_mem_en;
  assign mem_rw     = r_mem_rw;
  assign mem_data_w = r_mem_data_w;

endmodule

// File: tb/tb_elbeth_mem_arbiter.sv
// Directed bench for elbeth_mem_arbiter. Inputs change 1 ns after the
// rising edge. Registered outputs are checked there, and combinational
// responses 1 ns after the inputs change.
module tb_elbeth_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic          imem_en;
  logic [DW-1:0] imem_data;
  logic          imem_ready;
  logic          imem_error;
  logic [AW-1:0] dmem_addr;
  logic          dmem_en;
  logic [3:0]    dmem_rw;
  logic [DW-1:0] dmem_data_w;
  logic [DW-1:0] dmem_data_r;
  logic          dmem_ready;
  logic          dmem_error;
  logic [AW-1:0] mem_addr;
  logic          mem_en;
  logic [3:0]    mem_rw;
  logic [DW-1:0] mem_data_w;
  logic [DW-1:0] mem_data_r;
  logic          mem_ready;
  logic          mem_error;

  int checks;
  int failures;

`ifdef ELBETH_ARB_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  elbeth_mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_data  (imem_data),
    .imem_ready (imem_ready),
    .imem_error (imem_error),
    .dmem_addr  (dmem_addr),
    .dmem_en    (dmem_en),
    .dmem_rw    (dmem_rw),
    .dmem_data_w(dmem_data_w),
    .dmem_data_r(dmem_data_r),
    .dmem_ready (dmem_ready),
    .dmem_error (dmem_error),
    .mem_addr   (mem_addr),
    .mem_en     (mem_en),
    .mem_rw     (mem_rw),
    .mem_data_w (mem_data_w),
    .mem_data_r (mem_data_r),
    .mem_ready  (mem_ready),
    .mem_error  (mem_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dmem_en = 1'b1;
    dmem_addr = 32'h0000_0040;
    dmem_rw = 4'b0000;
    tick();
    tick();
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_mem_en: got %0h want 0", mem_en); end
    checks++;
    if (dmem_ready !== 1'b0) begin failures++; $display("FAIL reset_dmem_ready: got %0h want 0", dmem_ready); end
    checks++;
    if (mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    checks++;
    if (mem_rw !== 4'h0 || mem_data_w !== 32'h0) begin failures++; $display("FAIL reset_bus: got rw=%0h wd=%0h want 0 0", mem_rw, mem_data_w); end
    rst = 1'b1;
    tick();
    checks++;
    if (mem_en !== 1'b1) begin failures++; $display("FAIL reset_release_mem_en: got %0h want 1", mem_en); end
    checks++;
    if (mem_addr !== 32'h0000_0040) begin failures++; $display("FAIL reset_release_addr: got %0h want 40", mem_addr); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_ready !== 1'b1 || dmem_error !== 1'b0) begin failures++; $display("FAIL reset_first_done: got rdy=%0h err=%0h want 1 0", dmem_ready, dmem_error); end
    tick();
    dmem_en = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL reset_done_mem_en: got %0h want 0", mem_en); end
  endtask

  task automatic test_zero_wait_fetch();
    imem_en = 1'b1;
    imem_addr = 32'h0000_0100;
    mem_ready = 1'b1;
    mem_data_r = 32'h0000_0013;
    #1;
    checks++;
    if (imem_ready !== 1'b0) begin failures++; $display("FAIL fetch_idle_ready: got %0h want 0", imem_ready); end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_rw !== 4'h0) begin failures++; $display("FAIL fetch_bus: got en=%0h a=%0h rw=%0h want 1 100 0", mem_en, mem_addr, mem_rw); end
    checks++;
    if (imem_ready !== 1'b1 || imem_data !== 32'h13 || imem_error !== 1'b0) begin failures++; $display("FAIL fetch_resp: got rdy=%0h d=%0h err=%0h want 1 13 0", imem_ready, imem_data, imem_error); end
    checks++;
    if (dmem_ready !== 1'b0) begin failures++; $display("FAIL fetch_dmem_ready: got %0h want 0", dmem_ready); end
    tick();
    checks++;
    if (mem_en !== 1'b0 || imem_ready !== 1'b0) begin failures++; $display("FAIL fetch_gap: got en=%0h rdy=%0h want 0 0", mem_en, imem_ready); end
    tick();
    checks++;
    if (mem_en !== 1'b1 || imem_ready !== 1'b1) begin failures++; $display("FAIL fetch_regrant: got en=%0h rdy=%0h want 1 1", mem_en, imem_ready); end
    imem_en = 1'b0;
    #1;
    checks++;
    if (imem_ready !== 1'b0) begin failures++; $display("FAIL fetch_flush_ready: got %0h want 0", imem_ready); end
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL fetch_end_mem_en: got %0h want 0", mem_en); end
  endtask

  task automatic test_simultaneous();
    imem_en = 1'b1;
    imem_addr = 32'h0000_0300;
    dmem_en = 1'b1;
    dmem_rw = 4'b1111;
    dmem_addr = 32'h0000_2000;
    dmem_data_w = 32'hDEAD_BEEF;
    mem_data_r = 32'h1234_5678;
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h2000 || mem_rw !== 4'hF || mem_data_w !== 32'hDEADBEEF) begin
      failures++; $display("FAIL simul_d_bus: got en=%0h a=%0h rw=%0h wd=%0h want 1 2000 f deadbeef", mem_en, mem_addr, mem_rw, mem_data_w);
    end
    checks++;
    if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin failures++; $display("FAIL simul_wait1: got i=%0h d=%0h want 0 0", imem_ready, dmem_ready); end
    dmem_addr = 32'h0000_9999;
    dmem_data_w = 32'h0;
    tick();
    checks++;
    if (mem_addr !== 32'h2000 || mem_data_w !== 32'hDEADBEEF || mem_en !== 1'b1) begin
      failures++; $display("FAIL simul_hold: got a=%0h wd=%0h en=%0h want 2000 deadbeef 1", mem_addr, mem_data_w, mem_en);
    end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_ready !== 1'b1 || imem_ready !== 1'b0 || dmem_data_r !== 32'h12345678) begin
      failures++; $display("FAIL simul_d_done: got d=%0h i=%0h rd=%0h want 1 0 12345678", dmem_ready, imem_ready, dmem_data_r);
    end
    tick();
    dmem_en = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL simul_gap: got en=%0h want 0", mem_en); end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h300 || mem_rw !== 4'h0 || mem_data_w !== 32'h0) begin
      failures++; $display("FAIL simul_i_bus: got en=%0h a=%0h rw=%0h wd=%0h want 1 300 0 0", mem_en, mem_addr, mem_rw, mem_data_w);
    end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (imem_ready !== 1'b1) begin failures++; $display("FAIL simul_i_done: got %0h want 1", imem_ready); end
    tick();
    imem_en = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_abort_and_error();
    dmem_en = 1'b1;
    dmem_addr = 32'h0000_0500;
    dmem_rw = 4'b0000;
    imem_en = 1'b1;
    imem_addr = 32'h0000_0600;
    tick();
    tick();
    dmem_en = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b1 || dmem_ready !== 1'b0 || mem_addr !== 32'h500) begin
      failures++; $display("FAIL abort_c2: got en=%0h rdy=%0h a=%0h want 1 0 500", mem_en, dmem_ready, mem_addr);
    end
    tick();
    checks++;
    if (mem_en !== 1'b1) begin failures++; $display("FAIL abort_c3_en: got %0h want 1", mem_en); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_ready !== 1'b0 || imem_ready !== 1'b0) begin failures++; $display("FAIL abort_c4_ready: got d=%0h i=%0h want 0 0", dmem_ready, imem_ready); end
    tick();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL abort_gap: got en=%0h want 0", mem_en); end
    tick();
    checks++;
    if (mem_en !== 1'b1 || mem_addr !== 32'h600) begin failures++; $display("FAIL abort_fetch_grant: got en=%0h a=%0h want 1 600", mem_en, mem_addr); end
    mem_ready = 1'b1;
    mem_error = 1'b1;
    #1;
    checks++;
    if (imem_ready !== 1'b1 || imem_error !== 1'b1 || dmem_error !== 1'b0) begin
      failures++; $display("FAIL error_fetch: got rdy=%0h err=%0h derr=%0h want 1 1 0", imem_ready, imem_error, dmem_error);
    end
    tick();
    imem_en = 1'b0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    #1;
    checks++;
    if (imem_ready !== 1'b0 || imem_error !== 1'b0 || mem_en !== 1'b0) begin
      failures++; $display("FAIL error_clear: got rdy=%0h err=%0h en=%0h want 0 0 0", imem_ready, imem_error, mem_en);
    end
  endtask

  task automatic test_timeout();
    int bad;
    dmem_en = 1'b1;
    dmem_addr = 32'h0000_0700;
    dmem_rw = 4'b0000;
    mem_ready = 1'b0;
    tick();
`ifdef ELBETH_ARB_TIMEOUT_EN
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (dmem_ready !== 1'b0 || mem_en !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL timeout_early: got %0d bad cycles want 0", bad); end
    checks++;
    if (dmem_ready !== 1'b1 || dmem_error !== 1'b1 || mem_en !== 1'b1) begin
      failures++; $display("FAIL timeout_fire: got rdy=%0h err=%0h en=%0h want 1 1 1", dmem_ready, dmem_error, mem_en);
    end
    tick();
    dmem_en = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0 || dmem_ready !== 1'b0) begin failures++; $display("FAIL timeout_after: got en=%0h rdy=%0h want 0 0", mem_en, dmem_ready); end
`else
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (dmem_ready !== 1'b0 || dmem_error !== 1'b0 || mem_en !== 1'b1) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL hang_100: got %0d bad cycles want 0", bad); end
    mem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_ready !== 1'b1 || dmem_error !== 1'b0) begin failures++; $display("FAIL hang_done: got rdy=%0h err=%0h want 1 0", dmem_ready, dmem_error); end
    tick();
    dmem_en = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_en !== 1'b0) begin failures++; $display("FAIL hang_after: got en=%0h want 0", mem_en); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    imem_addr = '0;
    imem_en = 1'b0;
    dmem_addr = '0;
    dmem_en = 1'b0;
    dmem_rw = 4'b0000;
    dmem_data_w = '0;
    mem_data_r = '0;
    mem_ready = 1'b0;
    mem_error = 1'b0;
    test_reset();
    test_zero_wait_fetch();
    test_simultaneous();
    test_abort_and_error();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
